// File: rtl/aes_gcm_pkg.sv
// Shared types and constants for the GCM GHASH sequencer.
package aes_gcm_pkg;

  localparam int GCM_BLK_W = 128;
  localparam int GCM_LEN_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AAD,
    CT,
    LEN,
    WAIT_TAG
  } seq_state_t;

  typedef enum logic [1:0] {
    BT_AAD = 2'b00,
    BT_CT  = 2'b01,
    BT_LEN = 2'b10,
    BT_RSV = 2'b11
  } blk_type_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;

  // A GCM bit length is usable here only when it covers whole 128-bit blocks.
  function automatic logic len_aligned(input logic [GCM_LEN_W-1:0] len);
    return (len[6:0] == 7'd0);
  endfunction

endpackage

// File: rtl/aes_gcm_ghash_sequencer.sv
// Sequences one GCM authentication instance (AAD, CT, length block, tag)
// into a valid-only GHASH/tag stage.
module aes_gcm_ghash_sequencer
  import aes_gcm_pkg::*;
#(
  parameter int BLK_W  = GCM_BLK_W,
  parameter int LEN_W  = GCM_LEN_W,
  parameter int TAG_TO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_aad_len,
  input  logic [LEN_W-1:0] i_ct_len,
  input  logic [BLK_W-1:0] i_h,
  input  logic [BLK_W-1:0] i_encrypted_j0,
  input  logic             i_aad_valid,
  input  logic [BLK_W-1:0] i_aad,
  output logic             o_aad_ready,
  input  logic             i_ct_valid,
  input  logic [BLK_W-1:0] i_cipher_text,
  output logic             o_ct_ready,
  output logic             o_new_instance,
  output logic             o_blk_valid,
  output logic [BLK_W-1:0] o_blk,
  output logic [1:0]       o_blk_type,
  output logic [BLK_W-1:0] o_instance_size,
  output logic [BLK_W-1:0] o_h,
  output logic [BLK_W-1:0] o_encrypted_j0,
  input  logic             i_tag_ready,
  input  logic [BLK_W-1:0] i_tag,
  output logic             o_tag_valid,
  output logic [BLK_W-1:0] o_tag,
  output logic             o_busy,
  output logic [1:0]       o_err
);

  localparam int CNT_W = LEN_W - 7;
  localparam int TMR_W = $clog2(TAG_TO + 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_aad_cnt;
  logic [CNT_W-1:0] r_ct_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_new_instance;
  logic             r_blk_valid;
  logic [BLK_W-1:0] r_blk;
  blk_type_t        r_blk_type;
  logic [BLK_W-1:0] r_instance_size;
  logic [BLK_W-1:0] r_h;
  logic [BLK_W-1:0] r_encrypted_j0;
  logic             r_tag_valid;
  logic [BLK_W-1:0] r_tag;
  logic [1:0]       r_err;

  logic             w_in_aad;
  logic             w_hs;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_last;
  logic             w_len_ok;

  // Shared AAD/CT counter path: the active phase selects which counter steps.
  assign w_in_aad  = (r_state == AAD);
  assign w_hs      = (w_in_aad && i_aad_valid) || ((r_state == CT) && i_ct_valid);
  assign w_cnt_cur = w_in_aad ? r_aad_cnt : r_ct_cnt;
  assign w_cnt_dec = w_cnt_cur - CNT_W'(1);
  assign w_last    = (w_cnt_cur == CNT_W'(1));
  assign w_len_ok  = len_aligned(i_aad_len) && len_aligned(i_ct_len);

  // Ready and busy are pure decodes of the registered state.
  assign o_aad_ready     = (r_state == AAD);
  assign o_ct_ready      = (r_state == CT);
  assign o_busy          = (r_state != IDLE);
  assign o_new_instance  = r_new_instance;
  assign o_blk_valid     = r_blk_valid;
  assign o_blk           = r_blk;
  assign o_blk_type      = r_blk_type;
  assign o_instance_size = r_instance_size;
  assign o_h             = r_h;
  assign o_encrypted_j0  = r_encrypted_j0;
  assign o_tag_valid     = r_tag_valid;
  assign o_tag           = r_tag;
  assign o_err           = r_err;

  // Instance FSM with registered block, tag and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_aad_cnt       <= '0;
      r_ct_cnt        <= '0;
      r_timer         <= '0;
      r_new_instance  <= 1'b0;
      r_blk_valid     <= 1'b0;
      r_blk           <= '0;
      r_blk_type      <= BT_AAD;
      r_instance_size <= '0;
      r_h             <= '0;
      r_encrypted_j0  <= '0;
      r_tag_valid     <= 1'b0;
      r_tag           <= '0;
      r_err           <= ERR_NONE;
    end else begin
      r_new_instance <= 1'b0;
      r_blk_valid    <= 1'b0;
      r_tag_valid    <= 1'b0;
      r_err          <= ERR_NONE;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_instance_size <= {i_aad_len, i_ct_len};
              r_h             <= i_h;
              r_encrypted_j0  <= i_encrypted_j0;
              r_aad_cnt       <= i_aad_len[LEN_W-1:7];
              r_ct_cnt        <= i_ct_len[LEN_W-1:7];
              r_new_instance  <= 1'b1;
              r_state         <= INIT;
            end else begin
              r_err <= ERR_LEN;
            end
          end
        end
        INIT: begin
          if (r_aad_cnt != '0)     r_state <= AAD;
          else if (r_ct_cnt != '0) r_state <= CT;
          else                     r_state <= LEN;
        end
        AAD, CT: begin
          if (w_hs) begin
            r_blk_valid <= 1'b1;
            r_blk       <= w_in_aad ? i_aad : i_cipher_text;
            r_blk_type  <= w_in_aad ? BT_AAD : BT_CT;
            if (w_in_aad) r_aad_cnt <= w_cnt_dec;
            else          r_ct_cnt  <= w_cnt_dec;
            if (w_last) r_state <= (w_in_aad && (r_ct_cnt != '0)) ? CT : LEN;
          end
        end
        LEN: begin
          r_blk_valid <= 1'b1;
          r_blk       <= r_instance_size;
          r_blk_type  <= BT_LEN;
          r_timer     <= '0;
          r_state     <= WAIT_TAG;
        end
        WAIT_TAG: begin
          if (i_tag_ready) begin
            r_tag       <= i_tag;
            r_tag_valid <= 1'b1;
            r_state     <= IDLE;
          end else if (r_timer == TMR_W'(TAG_TO - 1)) begin
            r_err   <= ERR_TO;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_gcm_ghash_sequencer.sv
// Directed bench for aes_gcm_ghash_sequencer: one task per scenario.
module tb_aes_gcm_ghash_sequencer;

  localparam int TAG_TO = 64;
  localparam logic [127:0] H_VAL  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] J0_VAL = 128'h5A5A_1234_A5A5_5678_0F0F_9ABC_F0F0_DEF0;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [63:0]  i_aad_len;
  logic [63:0]  i_ct_len;
  logic [127:0] i_h;
  logic [127:0] i_encrypted_j0;
  logic         i_aad_valid;
  logic [127:0] i_aad;
  logic         o_aad_ready;
  logic         i_ct_valid;
  logic [127:0] i_cipher_text;
  logic         o_ct_ready;
  logic         o_new_instance;
  logic         o_blk_valid;
  logic [127:0] o_blk;
  logic [1:0]   o_blk_type;
  logic [127:0] o_instance_size;
  logic [127:0] o_h;
  logic [127:0] o_encrypted_j0;
  logic         i_tag_ready;
  logic [127:0] i_tag;
  logic         o_tag_valid;
  logic [127:0] o_tag;
  logic         o_busy;
  logic [1:0]   o_err;

  always #5 clk = ~clk;

  aes_gcm_ghash_sequencer #(.TAG_TO(TAG_TO)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_aad_len(i_aad_len), .i_ct_len(i_ct_len),
    .i_h(i_h), .i_encrypted_j0(i_encrypted_j0), .i_aad_valid(i_aad_valid), .i_aad(i_aad),
    .o_aad_ready(o_aad_ready), .i_ct_valid(i_ct_valid), .i_cipher_text(i_cipher_text),
    .o_ct_ready(o_ct_ready), .o_new_instance(o_new_instance), .o_blk_valid(o_blk_valid),
    .o_blk(o_blk), .o_blk_type(o_blk_type), .o_instance_size(o_instance_size), .o_h(o_h),
    .o_encrypted_j0(o_encrypted_j0), .i_tag_ready(i_tag_ready), .i_tag(i_tag),
    .o_tag_valid(o_tag_valid), .o_tag(o_tag), .o_busy(o_busy), .o_err(o_err)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] blk_q[$];
  logic [1:0]   typ_q[$];
  int           cyc_q[$];
  int n_new, n_tagv, n_err01, n_err10, n_both_rdy, n_any_rdy, n_busy;
  int cyc, len_cyc, tagrdy_cyc, tagv_cyc, err_cyc;
  logic [127:0] tag_seen;
  bit done;

  function automatic logic [127:0] aad_blk(input int k);
    return {64'hAAAA_0000_1111_2222, 64'(k)};
  endfunction

  function automatic logic [127:0] ct_blk(input int k);
    return {64'hCCCC_3333_4444_5555, 64'(k)};
  endfunction

  // Runs one instance from the bench side and records everything observed.
  task automatic drive_instance(input logic [63:0] alen, input logic [63:0] clen,
                                input bit ct_gap, input int tag_delay,
                                input logic [127:0] tag_val, input bit poke_start,
                                input bit stop_ct, input int max_cyc);
    int na, nc, ia, ic;
    na = int'(alen >> 7);
    nc = int'(clen >> 7);
    ia = 0; ic = 0;
    blk_q.delete(); typ_q.delete(); cyc_q.delete();
    n_new = 0; n_tagv = 0; n_err01 = 0; n_err10 = 0;
    n_both_rdy = 0; n_any_rdy = 0; n_busy = 0;
    len_cyc = -1; tagrdy_cyc = -1; tagv_cyc = -1; err_cyc = -1;
    done = 0; cyc = 0;
    @(negedge clk);
    i_start = 1'b1; i_aad_len = alen; i_ct_len = clen;
    i_h = H_VAL; i_encrypted_j0 = J0_VAL;
    i_aad = aad_blk(0); i_aad_valid = 1'b0;
    i_cipher_text = ct_blk(0); i_ct_valid = 1'b0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      i_tag_ready = 1'b0;
      if (o_new_instance) n_new++;
      if (o_aad_ready && o_ct_ready) n_both_rdy++;
      if (o_aad_ready || o_ct_ready) n_any_rdy++;
      if (o_busy) n_busy++;
      if (o_blk_valid) begin
        blk_q.push_back(o_blk);
        typ_q.push_back(o_blk_type);
        cyc_q.push_back(cyc);
        if (o_blk_type == 2'b10) len_cyc = cyc;
        if (stop_ct && o_blk_type == 2'b01) done = 1;
      end
      if (o_tag_valid) begin n_tagv++; tagv_cyc = cyc; tag_seen = o_tag; done = 1; end
      if (o_err == 2'b01) begin n_err01++; err_cyc = cyc; done = 1; end
      if (o_err == 2'b10) begin n_err10++; err_cyc = cyc; done = 1; end
      i_aad = aad_blk(ia);
      i_aad_valid = (ia < na);
      i_cipher_text = ct_blk(ic);
      i_ct_valid = (ic < nc) && !(ct_gap && (cyc % 2 == 1));
      if (o_aad_ready && i_aad_valid) ia++;
      if (o_ct_ready && i_ct_valid) ic++;
      if (poke_start && cyc == 4) begin i_start = 1'b1; i_aad_len = 64'd200; end
      if (tag_delay >= 0 && len_cyc >= 0 && cyc == len_cyc + tag_delay) begin
        i_tag_ready = 1'b1; i_tag = tag_val; tagrdy_cyc = cyc;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_bound: instance did not finish within %0d cycles", max_cyc);
    end
    i_aad_valid = 1'b0; i_ct_valid = 1'b0; i_tag_ready = 1'b0; i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 0; i_aad_len = 0; i_ct_len = 0; i_h = 0; i_encrypted_j0 = 0;
    i_aad_valid = 0; i_aad = 0; i_ct_valid = 0; i_cipher_text = 0; i_tag_ready = 0; i_tag = 0;
    repeat (3) @(negedge clk);
    checks++; if ({o_new_instance, o_blk_valid, o_tag_valid} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses: got %b want 000", {o_new_instance, o_blk_valid, o_tag_valid}); end
    checks++; if ({o_aad_ready, o_ct_ready, o_busy} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: got %b want 000", {o_aad_ready, o_ct_ready, o_busy}); end
    checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", o_err); end
    checks++; if ({o_blk, o_blk_type} !== 130'd0) begin errors++;
      $display("FAIL reset_blk: got %h/%b want 0", o_blk, o_blk_type); end
    checks++; if ({o_instance_size, o_h, o_encrypted_j0, o_tag} !== 512'd0) begin errors++;
      $display("FAIL reset_regs: got %h %h %h %h want 0", o_instance_size, o_h, o_encrypted_j0, o_tag); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [127:0] exp_b[6];
    logic [1:0]   exp_t[6];
    bit           consec;
    exp_b = '{aad_blk(0), aad_blk(1), ct_blk(0), ct_blk(1), ct_blk(2), {64'd256, 64'd384}};
    exp_t = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    drive_instance(64'd256, 64'd384, 1'b0, 2, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
                   1'b0, 1'b0, 60);
    checks++; if (n_new !== 1) begin errors++; $display("FAIL basic_new_inst: got %0d want 1", n_new); end
    checks++; if (blk_q.size() !== 6) begin errors++;
      $display("FAIL basic_blk_count: got %0d want 6", blk_q.size()); end
    for (int k = 0; k < 6 && k < blk_q.size(); k++) begin
      checks++; if (blk_q[k] !== exp_b[k] || typ_q[k] !== exp_t[k]) begin errors++;
        $display("FAIL basic_blk%0d: got %h/%b want %h/%b", k, blk_q[k], typ_q[k], exp_b[k], exp_t[k]); end
    end
    consec = 1;
    for (int k = 0; k < cyc_q.size(); k++) if (cyc_q[k] != cyc_q[0] + k) consec = 0;
    checks++; if (!consec || cyc_q.size() == 0 || cyc_q[0] != 3) begin errors++;
      $display("FAIL basic_timing: first blk cycle %0d want 3, consecutive=%0d want 1",
               (cyc_q.size() > 0) ? cyc_q[0] : -1, consec); end
    checks++; if (tag_seen !== 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555 || tagv_cyc != tagrdy_cyc + 1)
      begin errors++; $display("FAIL basic_tag: got %h at +%0d want DEADBEEF.. at +1", tag_seen,
                               tagv_cyc - tagrdy_cyc); end
    checks++; if (n_both_rdy !== 0) begin errors++;
      $display("FAIL basic_both_ready: got %0d cycles want 0", n_both_rdy); end
    @(negedge clk);
    checks++; if (o_h !== H_VAL || o_encrypted_j0 !== J0_VAL || o_instance_size !== {64'd256, 64'd384})
      begin errors++; $display("FAIL basic_latched: got %h %h %h", o_h, o_encrypted_j0, o_instance_size); end
    checks++; if (o_busy !== 1'b0 || o_tag !== 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555) begin errors++;
      $display("FAIL basic_idle: busy=%b tag=%h want 0 and held tag", o_busy, o_tag); end
  endtask

  task automatic test_bubble();
    logic [127:0] exp_b[6];
    exp_b = '{aad_blk(0), aad_blk(1), ct_blk(0), ct_blk(1), ct_blk(2), {64'd256, 64'd384}};
    drive_instance(64'd256, 64'd384, 1'b1, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                   1'b1, 1'b0, 60);
    checks++; if (blk_q.size() !== 6) begin errors++;
      $display("FAIL bubble_blk_count: got %0d want 6", blk_q.size()); end
    for (int k = 0; k < 6 && k < blk_q.size(); k++) begin
      checks++; if (blk_q[k] !== exp_b[k]) begin errors++;
        $display("FAIL bubble_blk%0d: got %h want %h", k, blk_q[k], exp_b[k]); end
    end
    checks++; if (cyc_q.size() == 6 && (cyc_q[4] - cyc_q[2]) < 3) begin errors++;
      $display("FAIL bubble_spacing: CT span %0d want >=3", cyc_q[4] - cyc_q[2]); end
    checks++; if (n_err01 !== 0 || n_new !== 1) begin errors++;
      $display("FAIL bubble_start_ignored: err01=%0d new=%0d want 0/1", n_err01, n_new); end
    checks++; if (tag_seen !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin errors++;
      $display("FAIL bubble_tag: got %h", tag_seen); end
  endtask

  task automatic test_zero();
    drive_instance(64'd0, 64'd0, 1'b0, 1, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F,
                   1'b0, 1'b0, 30);
    checks++; if (n_new !== 1 || blk_q.size() !== 1) begin errors++;
      $display("FAIL zero_shape: new=%0d blocks=%0d want 1/1", n_new, blk_q.size()); end
    checks++; if (blk_q.size() > 0 && (blk_q[0] !== 128'd0 || typ_q[0] !== 2'b10 || cyc_q[0] != 3)) begin
      errors++; $display("FAIL zero_len_blk: got %h/%b at %0d want 0/10 at 3", blk_q[0], typ_q[0], cyc_q[0]); end
    checks++; if (n_any_rdy !== 0) begin errors++;
      $display("FAIL zero_ready: got %0d ready cycles want 0", n_any_rdy); end
    checks++; if (n_tagv !== 1 || tag_seen !== 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F) begin
      errors++; $display("FAIL zero_tag: pulses=%0d tag=%h", n_tagv, tag_seen); end
  endtask

  task automatic test_len_err();
    drive_instance(64'd200, 64'd128, 1'b0, 0, 128'd0, 1'b0, 1'b0, 10);
    checks++; if (n_err01 !== 1 || err_cyc != 1) begin errors++;
      $display("FAIL lenerr_pulse: count=%0d cycle=%0d want 1/1", n_err01, err_cyc); end
    repeat (3) begin
      @(negedge clk);
      if (o_busy) n_busy++;
      if (o_new_instance) n_new++;
      if (o_err != 2'b00) n_err01++;
    end
    checks++; if (n_busy !== 0 || n_new !== 0) begin errors++;
      $display("FAIL lenerr_idle: busy=%0d new=%0d want 0/0", n_busy, n_new); end
    checks++; if (n_err01 !== 1) begin errors++;
      $display("FAIL lenerr_one_cycle: got %0d err cycles want 1", n_err01); end
  endtask

  task automatic test_timeout();
    logic [127:0] prev_tag;
    prev_tag = o_tag;
    drive_instance(64'd128, 64'd128, 1'b0, -1, 128'd0, 1'b0, 1'b0, 200);
    checks++; if (n_err10 !== 1 || len_cyc < 0 || err_cyc - len_cyc != TAG_TO) begin errors++;
      $display("FAIL timeout_delay: count=%0d delay=%0d want 1/%0d", n_err10, err_cyc - len_cyc, TAG_TO); end
    checks++; if (n_tagv !== 0 || o_tag !== prev_tag) begin errors++;
      $display("FAIL timeout_tag: pulses=%0d tag=%h want 0/%h", n_tagv, o_tag, prev_tag); end
    i_tag_ready = 1'b1; i_tag = 128'hBAD0;
    @(negedge clk);
    i_tag_ready = 1'b0;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_tag_valid !== 1'b0 || o_tag !== prev_tag) begin errors++;
      $display("FAIL timeout_idle: busy=%b tagv=%b tag=%h", o_busy, o_tag_valid, o_tag); end
  endtask

  task automatic test_rst_mid();
    drive_instance(64'd256, 64'd384, 1'b0, 0, 128'd0, 1'b0, 1'b1, 30);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({o_new_instance, o_blk_valid, o_tag_valid, o_aad_ready, o_ct_ready, o_busy, o_err,
                   o_blk_type} !== 10'd0) begin errors++; $display("FAIL rstmid_ctrl: not all zero"); end
    checks++; if ({o_blk, o_instance_size, o_h, o_encrypted_j0, o_tag} !== 640'd0) begin errors++;
      $display("FAIL rstmid_data: blk=%h size=%h tag=%h want 0", o_blk, o_instance_size, o_tag); end
    rst = 1'b0;
    drive_instance(64'd256, 64'd384, 1'b0, 0, 128'h7777_0000_0000_0000_0000_0000_0000_0001,
                   1'b0, 1'b0, 60);
    checks++; if (n_new !== 1 || blk_q.size() !== 6 || n_tagv !== 1) begin errors++;
      $display("FAIL rstmid_rerun: new=%0d blocks=%0d tags=%0d want 1/6/1", n_new, blk_q.size(), n_tagv); end
    checks++; if (tag_seen !== 128'h7777_0000_0000_0000_0000_0000_0000_0001) begin errors++;
      $display("FAIL rstmid_tag: got %h", tag_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_zero();
    test_len_err();
    test_timeout();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
